fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_stage.sv | 86 ++++++++
 tb/tb_fetch_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundle (redirect/stall control, instruction memory, IF/ID outputs; counters under FETCH_PERF_EN)
interface fetch_if;
  logic        stall;
  logic        PCSel;
  logic        flush;
  logic [31:0] alu_MEM;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_ID;
  logic [31:0] inst_ID;
  logic        valid_ID;
  logic        boot_done;
`ifdef FETCH_PERF_EN
  logic [31:0] ctr_flush;
  logic [31:0] ctr_stall;
`endif
  modport slave (
    input  stall, PCSel, flush, alu_MEM, imem_rdata,
    output imem_addr, pc_ID, inst_ID, valid_ID, boot_done
`ifdef FETCH_PERF_EN
    , output ctr_flush, ctr_stall
`endif
  );
  modport master (
    output stall, PCSel, flush, alu_MEM, imem_rdata,
    input  imem_addr, pc_ID, inst_ID, valid_ID, boot_done
`ifdef FETCH_PERF_EN
    , input ctr_flush, ctr_stall
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID register; FETCH_PERF_EN adds saturating flush/stall counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic        valid_id_q, valid_id_d;
  logic        redirect;
  logic        run;
  assign redirect = bus.PCSel | bus.flush;
  assign run = state_q == RUN;
  // next-state: BOOT parks the pipe on a bubble; RUN picks redirect > stall > sequential
  always_comb begin
    state_d    = RUN;
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    inst_id_d  = inst_id_q;
    valid_id_d = valid_id_q;
    if (!run) begin
      pc_d       = RESET_PC;
      pc_id_d    = RESET_PC;
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
    end else if (redirect) begin
      pc_d       = bus.alu_MEM;
      pc_id_d    = pc_q;
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d       = pc_q + 32'd4;
      pc_id_d    = pc_q;
      inst_id_d  = bus.imem_rdata;
      valid_id_d = 1'b1;
    end
  end
  // state, PC and IF/ID registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_id_q    <= RESET_PC;
      inst_id_q  <= NOP_INST;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      inst_id_q  <= inst_id_d;
      valid_id_q <= valid_id_d;
    end
  end
  assign bus.imem_addr = pc_q;
  assign bus.pc_ID     = pc_id_q;
  assign bus.inst_ID   = inst_id_q;
  assign bus.valid_ID  = valid_id_q;
  assign bus.boot_done = run;
`ifdef FETCH_PERF_EN
  logic [31:0] ctr_flush_q, ctr_flush_d;
  logic [31:0] ctr_stall_q, ctr_stall_d;
  // saturating event counts, live only in RUN; a stall under redirect is not a stall
  always_comb begin
    ctr_flush_d = (run && redirect && ctr_flush_q != '1) ? ctr_flush_q + 32'd1 : ctr_flush_q;
    ctr_stall_d = (run && !redirect && bus.stall && ctr_stall_q != '1) ? ctr_stall_q + 32'd1 : ctr_stall_q;
  end
  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_flush_q <= '0;
      ctr_stall_q <= '0;
    end else begin
      ctr_flush_q <= ctr_flush_d;
      ctr_stall_q <= ctr_stall_d;
    end
  end
  assign bus.ctr_flush = ctr_flush_q;
  assign bus.ctr_stall = ctr_stall_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus reset/boot sequences for fetch_stage (counter checks under FETCH_PERF_EN)
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  fetch_if f();
  fetch_stage dut (.clk(clk), .rst(rst), .bus(f));
  always #5 clk = ~clk;
  assign f.imem_rdata = (f.imem_addr == 32'h0) ? 32'h0010_0093 : (f.imem_addr ^ 32'hA5A5_0000);
  typedef struct {
    logic        stall;
    logic        pcsel;
    logic        flush;
    logic [31:0] alu;
    logic [31:0] addr;
    logic [31:0] pc_id;
    logic [31:0] inst;
    logic        valid;
  } vec_t;
  vec_t vecs [14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic s, input logic p, input logic fl, input logic [31:0] a);
    f.stall = s;
    f.PCSel = p;
    f.flush = fl;
    f.alu_MEM = a;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, " imem_addr"}, f.imem_addr, 32'h0);
    chk({tag, " pc_ID"}, f.pc_ID, 32'h0);
    chk({tag, " inst_ID"}, f.inst_ID, 32'h13);
    chk({tag, " valid_ID"}, {31'h0, f.valid_ID}, 32'h0);
    chk({tag, " boot_done"}, {31'h0, f.boot_done}, 32'h0);
`ifdef FETCH_PERF_EN
    chk({tag, " ctr_flush"}, f.ctr_flush, 32'h0);
    chk({tag, " ctr_stall"}, f.ctr_stall, 32'h0);
`endif
  endtask
  initial begin
    vecs[0]  = '{0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h0010_0093, 1};
    vecs[1]  = '{0, 0, 0, 32'h0,        32'h8,        32'h4,        32'hA5A5_0004, 1};
    vecs[2]  = '{0, 0, 1, 32'h10,       32'h10,       32'h8,        32'h13,        0};
    vecs[3]  = '{1, 0, 0, 32'h0,        32'h10,       32'h8,        32'h13,        0};
    vecs[4]  = '{1, 0, 0, 32'h0,        32'h10,       32'h8,        32'h13,        0};
    vecs[5]  = '{1, 0, 0, 32'h0,        32'h10,       32'h8,        32'h13,        0};
    vecs[6]  = '{0, 0, 0, 32'h0,        32'h14,       32'h10,       32'hA5A5_0010, 1};
    vecs[7]  = '{0, 1, 0, 32'h24,       32'h24,       32'h14,       32'h13,        0};
    vecs[8]  = '{0, 0, 1, 32'h80,       32'h80,       32'h24,       32'h13,        0};
    vecs[9]  = '{1, 1, 0, 32'h200,      32'h200,      32'h80,       32'h13,        0};
    vecs[10] = '{0, 0, 0, 32'h0,        32'h204,      32'h200,      32'hA5A5_0200, 1};
    vecs[11] = '{0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h204,     32'h13,        0};
    vecs[12] = '{0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h5A5A_FFFC, 1};
    vecs[13] = '{0, 0, 1, 32'h103,      32'h103,      32'h0,        32'h13,        0};
    rst = 1'b1;
    drive(0, 0, 0, 32'h0);
    #12;
    chk_reset_vals("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    chk("boot imem_addr", f.imem_addr, 32'h0);
    chk("boot valid_ID", {31'h0, f.valid_ID}, 32'h0);
    chk("boot boot_done", {31'h0, f.boot_done}, 32'h1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk) drive(vecs[i].stall, vecs[i].pcsel, vecs[i].flush, vecs[i].alu);
      @(posedge clk) #1;
      chk($sformatf("v%0d imem_addr", i), f.imem_addr, vecs[i].addr);
      chk($sformatf("v%0d pc_ID", i), f.pc_ID, vecs[i].pc_id);
      chk($sformatf("v%0d inst_ID", i), f.inst_ID, vecs[i].inst);
      chk($sformatf("v%0d valid_ID", i), {31'h0, f.valid_ID}, {31'h0, vecs[i].valid});
    end
`ifdef FETCH_PERF_EN
    chk("ctr_flush", f.ctr_flush, 32'd6);
    chk("ctr_stall", f.ctr_stall, 32'd3);
`endif
    @(negedge clk) drive(0, 1, 0, 32'h300);
    @(posedge clk) #1;
    chk("redir imem_addr", f.imem_addr, 32'h300);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    chk_reset_vals("held reset");
    rst = 1'b0;
    drive(1, 1, 0, 32'h500);
    @(posedge clk) #1;
    chk("reboot imem_addr", f.imem_addr, 32'h0);
    chk("reboot valid_ID", {31'h0, f.valid_ID}, 32'h0);
    chk("reboot boot_done", {31'h0, f.boot_done}, 32'h1);
    @(negedge clk) drive(0, 0, 0, 32'h0);
    @(posedge clk) #1;
    chk("first inst_ID", f.inst_ID, 32'h0010_0093);
    chk("first pc_ID", f.pc_ID, 32'h0);
    chk("first valid_ID", {31'h0, f.valid_ID}, 32'h1);
    chk("first imem_addr", f.imem_addr, 32'h4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
